// File: rtl/rr_mux_arbiter.sv
// rtl/rr_mux_arbiter.sv - registered two-input round-robin stream arbiter with per-source beat counters
module rr_mux_arbiter #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a_data,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [WIDTH-1:0] b_data,
  input  logic             b_valid,
  output logic             b_ready,
  output logic [WIDTH-1:0] y_data,
  output logic             y_valid,
  input  logic             y_ready,
  output logic             sel,
  output logic [CNT_W-1:0] a_cnt,
  output logic [CNT_W-1:0] b_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Tie-break pointer: 0 means A wins the next contention, 1 means B.
  logic prio;
  logic ld;
  logic grant_a;
  logic grant_b;
  logic take_a;
  logic take_b;

  // Grant and handshake decode; readies are forced low while reset is held.
  always_comb begin
    ld      = !y_valid || y_ready;
    grant_a = a_valid && (!b_valid || !prio);
    grant_b = b_valid && (!a_valid ||  prio);
    take_a  = ld && grant_a;
    take_b  = ld && grant_b;
    a_ready = rst_n && take_a;
    b_ready = rst_n && take_b;
  end

  // Output beat register, source tag and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_data  <= '0;
      y_valid <= 1'b0;
      sel     <= 1'b0;
      prio    <= 1'b0;
    end else if (take_a) begin
      y_data  <= a_data;
      y_valid <= 1'b1;
      sel     <= 1'b0;
      prio    <= 1'b1;
    end else if (take_b) begin
      y_data  <= b_data;
      y_valid <= 1'b1;
      sel     <= 1'b1;
      prio    <= 1'b0;
    end else if (ld) begin
      y_valid <= 1'b0;
    end
  end

  // Saturating accepted-beat counters, one per source.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_cnt <= '0;
      b_cnt <= '0;
    end else begin
      if (take_a && a_cnt != CNT_MAX) a_cnt <= a_cnt + CNT_W'(1);
      if (take_b && b_cnt != CNT_MAX) b_cnt <= b_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// tb/tb_rr_mux_arbiter.sv - self-checking bench for rr_mux_arbiter against a behavioural model
module tb_rr_mux_arbiter;

  localparam int W    = 8;
  localparam int CW   = 16;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [W-1:0]  a_data, b_data, y_data;
  logic          a_valid, b_valid, a_ready, b_ready;
  logic          y_valid, y_ready, sel;
  logic [CW-1:0] a_cnt, b_cnt;

  logic [W-1:0]  s_a_data, s_b_data, s_y_data;
  logic          s_a_valid, s_b_valid, s_a_ready, s_b_ready;
  logic          s_y_valid, s_y_ready, s_sel;
  logic [1:0]    s_a_cnt, s_b_cnt;

  int checks   = 0;
  int failures = 0;

  // Model state: what the output register and counters should hold.
  logic         m_yv;
  logic [W-1:0] m_yd;
  logic         m_sel;
  int           m_turn;
  int           m_acnt, m_bcnt;

  always #5 clk = ~clk;

  rr_mux_arbiter #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_data(a_data), .a_valid(a_valid), .a_ready(a_ready),
    .b_data(b_data), .b_valid(b_valid), .b_ready(b_ready),
    .y_data(y_data), .y_valid(y_valid), .y_ready(y_ready),
    .sel(sel), .a_cnt(a_cnt), .b_cnt(b_cnt)
  );

  rr_mux_arbiter #(.WIDTH(W), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n),
    .a_data(s_a_data), .a_valid(s_a_valid), .a_ready(s_a_ready),
    .b_data(s_b_data), .b_valid(s_b_valid), .b_ready(s_b_ready),
    .y_data(s_y_data), .y_valid(s_y_valid), .y_ready(s_y_ready),
    .sel(s_sel), .a_cnt(s_a_cnt), .b_cnt(s_b_cnt)
  );

  function automatic int winner();
    // 0 = A, 1 = B, -1 = nobody accepted this cycle
    if (!rst_n) return -1;
    if (m_yv && !y_ready) return -1;
    if (a_valid && b_valid) return m_turn;
    if (a_valid) return 0;
    if (b_valid) return 1;
    return -1;
  endfunction

  function automatic logic exp_ar();
    return winner() == 0;
  endfunction

  function automatic logic exp_br();
    return winner() == 1;
  endfunction

  task automatic model_reset();
    m_yv = 1'b0; m_yd = '0; m_sel = 1'b0; m_turn = 0; m_acnt = 0; m_bcnt = 0;
  endtask

  task automatic advance();
    int w;
    logic free;
    logic [W-1:0] ad, bd;
    w = winner(); free = !m_yv || y_ready; ad = a_data; bd = b_data;
    @(posedge clk);
    if (w == 0) begin
      m_yv = 1'b1; m_yd = ad; m_sel = 1'b0; m_turn = 1;
      if (m_acnt < CMAX) m_acnt++;
    end else if (w == 1) begin
      m_yv = 1'b1; m_yd = bd; m_sel = 1'b1; m_turn = 0;
      if (m_bcnt < CMAX) m_bcnt++;
    end else if (rst_n && free) begin
      m_yv = 1'b0;
    end
    #1;
  endtask

  task automatic idle_inputs();
    a_valid = 0; b_valid = 0; y_ready = 1; a_data = '0; b_data = '0;
    s_a_valid = 0; s_b_valid = 0; s_y_ready = 1; s_a_data = '0; s_b_data = '0;
  endtask

  task automatic reset_dut();
    idle_inputs();
    @(negedge clk);
    rst_n = 0;
    model_reset();
    @(posedge clk);
    #1 rst_n = 1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0; a_valid = 1; b_valid = 1; a_data = 8'h33; b_data = 8'h44;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (y_valid !== 1'b0) begin failures++; $display("FAIL reset_y_valid got=%0b exp=0", y_valid); end
    checks++; if (sel !== 1'b0) begin failures++; $display("FAIL reset_sel got=%0b exp=0", sel); end
    checks++; if (y_data !== 8'h00) begin failures++; $display("FAIL reset_y_data got=%h exp=00", y_data); end
    checks++; if (a_cnt !== 16'd0 || b_cnt !== 16'd0) begin failures++; $display("FAIL reset_cnts got=%0d/%0d exp=0/0", a_cnt, b_cnt); end
    checks++; if (a_ready !== 1'b0 || b_ready !== 1'b0) begin failures++; $display("FAIL reset_readies got=%0b/%0b exp=0/0", a_ready, b_ready); end
    a_valid = 0; b_valid = 0;
    rst_n = 1;
  endtask

  task automatic test_single_source();
    a_data = 8'h5A; a_valid = 1; b_valid = 0; y_ready = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (a_ready !== 1'b1 || b_ready !== 1'b0) begin failures++; $display("FAIL single_ready[%0d] got=%0b/%0b exp=1/0", i, a_ready, b_ready); end
      advance();
      checks++; if (y_valid !== 1'b1 || y_data !== 8'h5A || sel !== 1'b0) begin failures++; $display("FAIL single_out[%0d] got v=%0b d=%h s=%0b exp v=1 d=5a s=0", i, y_valid, y_data, sel); end
    end
    a_valid = 0;
    checks++; if (a_cnt !== 16'd4 || b_cnt !== 16'd0) begin failures++; $display("FAIL single_cnts got=%0d/%0d exp=4/0", a_cnt, b_cnt); end
  endtask

  task automatic test_contention();
    logic [W-1:0] exp_d [6];
    logic [W-1:0] a_next, b_next;
    exp_d[0] = 8'h10; exp_d[1] = 8'h20; exp_d[2] = 8'h11;
    exp_d[3] = 8'h21; exp_d[4] = 8'h12; exp_d[5] = 8'h22;
    reset_dut();
    a_next = 8'h10; b_next = 8'h20;
    for (int i = 0; i < 6; i++) begin
      a_data = a_next; b_data = b_next; a_valid = 1; b_valid = 1; y_ready = 1;
      #1;
      checks++; if (a_ready !== (i % 2 == 0) || b_ready !== (i % 2 == 1)) begin failures++; $display("FAIL contention_ready[%0d] got=%0b/%0b", i, a_ready, b_ready); end
      advance();
      if (i % 2 == 0) a_next++; else b_next++;
      checks++; if (y_data !== exp_d[i] || sel !== logic'(i % 2) || y_valid !== 1'b1) begin failures++; $display("FAIL contention_out[%0d] got d=%h s=%0b exp d=%h s=%0d", i, y_data, sel, exp_d[i], i % 2); end
    end
  endtask

  task automatic test_backpressure();
    a_data = 8'h13; b_data = 8'h23; a_valid = 1; b_valid = 1; y_ready = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (a_ready !== 1'b0 || b_ready !== 1'b0) begin failures++; $display("FAIL bp_ready[%0d] got=%0b/%0b exp=0/0", i, a_ready, b_ready); end
      advance();
      checks++; if (y_data !== 8'h22 || sel !== 1'b1 || y_valid !== 1'b1 || a_cnt !== 16'd3 || b_cnt !== 16'd3) begin failures++; $display("FAIL bp_hold[%0d] got d=%h s=%0b v=%0b c=%0d/%0d exp d=22 s=1 v=1 c=3/3", i, y_data, sel, y_valid, a_cnt, b_cnt); end
    end
    y_ready = 1;
    #1;
    checks++; if (a_ready !== 1'b1 || b_ready !== 1'b0) begin failures++; $display("FAIL bp_resume_ready got=%0b/%0b exp=1/0", a_ready, b_ready); end
    advance();
    checks++; if (y_data !== 8'h13 || sel !== 1'b0) begin failures++; $display("FAIL bp_resume_a got d=%h s=%0b exp d=13 s=0", y_data, sel); end
    advance();
    checks++; if (y_data !== 8'h23 || sel !== 1'b1) begin failures++; $display("FAIL bp_resume_b got d=%h s=%0b exp d=23 s=1", y_data, sel); end
    a_valid = 0; b_valid = 0;
    advance();
    checks++; if (y_valid !== 1'b0 || y_data !== 8'h23 || sel !== 1'b1) begin failures++; $display("FAIL bp_drain got v=%0b d=%h s=%0b exp v=0 d=23 s=1", y_valid, y_data, sel); end
  endtask

  task automatic test_reset_midstream();
    a_valid = 0; b_valid = 1; b_data = 8'h77; y_ready = 0;
    advance();
    b_valid = 0;
    checks++; if (y_valid !== 1'b1 || sel !== 1'b1) begin failures++; $display("FAIL mid_setup got v=%0b s=%0b exp v=1 s=1", y_valid, sel); end
    rst_n = 0;
    model_reset();
    #1;
    checks++; if (y_valid !== 1'b0 || sel !== 1'b0 || y_data !== 8'h00) begin failures++; $display("FAIL mid_reset_out got v=%0b s=%0b d=%h exp 0/0/00", y_valid, sel, y_data); end
    checks++; if (a_cnt !== 16'd0 || b_cnt !== 16'd0) begin failures++; $display("FAIL mid_reset_cnts got=%0d/%0d exp=0/0", a_cnt, b_cnt); end
    #2 rst_n = 1;
    a_valid = 1; b_valid = 1; a_data = 8'hA1; b_data = 8'hB1; y_ready = 1;
    #1;
    checks++; if (a_ready !== 1'b1 || b_ready !== 1'b0) begin failures++; $display("FAIL mid_tie_ready got=%0b/%0b exp=1/0", a_ready, b_ready); end
    advance();
    checks++; if (y_data !== 8'hA1 || sel !== 1'b0) begin failures++; $display("FAIL mid_tie_out got d=%h s=%0b exp d=a1 s=0", y_data, sel); end
    a_valid = 0; b_valid = 0;
  endtask

  task automatic test_random();
    int errs;
    reset_dut();
    errs = 0;
    for (int i = 0; i < 400; i++) begin
      a_valid = ($urandom_range(0, 3) != 0);
      b_valid = ($urandom_range(0, 3) != 0);
      y_ready = ($urandom_range(0, 2) != 0);
      a_data  = W'($urandom);
      b_data  = W'($urandom);
      #1;
      checks++;
      if (a_ready !== exp_ar() || b_ready !== exp_br()) begin
        failures++; errs++;
        if (errs < 10) $display("FAIL rand_ready[%0d] got=%0b/%0b exp=%0b/%0b", i, a_ready, b_ready, exp_ar(), exp_br());
      end
      advance();
      checks++;
      if (y_valid !== m_yv || y_data !== m_yd || sel !== m_sel || a_cnt !== CW'(m_acnt) || b_cnt !== CW'(m_bcnt)) begin
        failures++; errs++;
        if (errs < 10) $display("FAIL rand_state[%0d] got v=%0b d=%h s=%0b c=%0d/%0d exp v=%0b d=%h s=%0b c=%0d/%0d",
                                i, y_valid, y_data, sel, a_cnt, b_cnt, m_yv, m_yd, m_sel, m_acnt, m_bcnt);
      end
    end
    idle_inputs();
  endtask

  task automatic test_saturation();
    int exp_c;
    reset_dut();
    s_b_valid = 1; s_y_ready = 1;
    for (int k = 1; k <= 5; k++) begin
      s_b_data = W'($urandom);
      advance();
      exp_c = (k > 3) ? 3 : k;
      checks++; if (s_b_cnt !== 2'(exp_c) || s_a_cnt !== 2'd0) begin failures++; $display("FAIL sat_cnt[%0d] got=%0d/%0d exp=0/%0d", k, s_a_cnt, s_b_cnt, exp_c); end
    end
    s_b_valid = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish exp=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    rst_n = 0;
    model_reset();
    test_reset();
    test_single_source();
    test_contention();
    test_backpressure();
    test_reset_midstream();
    test_random();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
